clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable integer clock divider with parametrised ratio width, glitch-free ratio changes at period boundaries, and graceful start/stop. It produces a divided clock plus a one-cycle rise strobe for logic that stays in the reference domain. It is the next-generation divider for the UART, baud and peripheral clock trees of the CREM subsystem.

## Interface

**Parameters**
- `RATIO_W`, default 8: width of the divide ratio and internal counter. Maximum ratio is 2^RATIO_W−1.
- `RST_RATIO`, default 2: active ratio loaded at reset. Must be ≥2 and < 2^RATIO_W.

**Ports**
- `i_ref_clk`, in, 1: reference clock. All flops use its rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_clk_en`, in, 1: run request.
- `i_div_ratio`, in, RATIO_W: new ratio N, sampled when `i_ratio_vld`=1.
- `i_ratio_vld`, in, 1: one-cycle load strobe for `i_div_ratio`.
- `o_ratio_ack`, out, 1: one-cycle pulse when a pending ratio becomes active.
- `o_busy`, out, 1: a loaded ratio is pending and not yet active.
- `o_div_clk`, out, 1: divided clock.
- `o_rise_pls`, out, 1: high for the single ref cycle in which `o_div_clk` rises.

## Operation

**Reset.** All registered outputs are 0: `o_div_clk` register, `o_rise_pls`, `o_ratio_ack`, `o_busy`. Active ratio = `RST_RATIO`, state = IDLE, counter = 0, pending = 0.

**Ratio load.**
- When `i_ratio_vld`=1, store `i_div_ratio` in a shadow register and set pending (`o_busy`=1).
- A second load before apply overwrites the shadow; only one ack is produced.
- Apply points:
  - In IDLE: the next edge after the load.
  - In RUN: the next boundary edge (the edge where `o_div_clk` rises).
- At the apply edge: active ratio ← shadow, pending ← 0, `o_ratio_ack` pulses for 1 cycle.
- A load sampled on a boundary edge is not applied at that edge; it waits for the following boundary.

**Phase lengths** (active ratio N). High phase H = N − (N>>1), i.e. ceil(N/2). Low phase L = N>>1. Even N gives 50% duty; odd N is high one cycle longer than low.

**State machine: IDLE, HI, LO.**
- IDLE → HI when `i_clk_en`=1 and active N ≥ 2, evaluated after any same-edge apply. That edge is a boundary: register ← 1, `o_rise_pls` ← 1, counter ← 0.
- HI: counter increments each edge. When counter = H−1: → LO, register ← 0, counter ← 0.
- LO: counter increments each edge. When counter = L−1:
  - if `i_clk_en`=1 and new N ≥ 2: → HI as a boundary (pending apply first, then H/L recomputed from the new N);
  - otherwise → IDLE, register stays 0.
- `i_clk_en` deasserting during HI or LO does not truncate the period. The divider stops only at the end of LO, so no runt pulses occur.
- Active N of 0 or 1 keeps the block in IDLE.
- The counter uses RATIO_W bits and never wraps within a phase.

## Timing

- Start latency: `i_clk_en` sampled high at edge k gives `o_div_clk` high after edge k, low after edge k+H, high again after edge k+N.
- `o_rise_pls` is high after edges k, k+N, k+2N, …
- `o_ratio_ack` coincides with the `o_rise_pls` of the first period at the new ratio; in IDLE it occurs one edge after the load.
- Stop latency: at most N−1 edges after `i_clk_en` falls.
- Reset assertion mid-period forces all outputs to 0 immediately, asynchronously.

## Configuration

Macro: `CLKDIV_BYPASS_EN`.
- **Defined:** when state is IDLE and `i_clk_en`=1 with active N of 0 or 1, `o_div_clk` = `i_ref_clk` through a combinational mux; `o_rise_pls` stays 0. All other IDLE cases drive the register (0).
- **Undefined:** `o_div_clk` is always the register output. N of 0 or 1 leaves the output low in IDLE.

## Test plan

- **Even ratio, reset default:** reset, `i_clk_en`=1, N=2 → period 2; high 1, low 1; `o_rise_pls` every 2 cycles; `o_ratio_ack` never pulses.
- **Odd ratio from IDLE:** load N=5 in IDLE, then enable → ack 1 cycle after load; high 3, low 2; first rise on the enable edge.
- **Mid-run change:** running N=4, load N=7 mid-HI → `o_busy`=1 until the next rise; ack with that rise; the following period is 4 high / 3 low; no short pulse.
- **Graceful stop:** running N=6, drop `i_clk_en` one cycle into HI → 3 high then 3 low complete, then IDLE with output 0; `o_rise_pls` stays 0 afterwards.
- **Bypass (`CLKDIV_BYPASS_EN`):** load N=1, enable → `o_div_clk` follows `i_ref_clk`. Without the macro, the output stays 0. Then load N=3 → divided operation begins with the ack.
- **Async reset mid-run:** N=9, assert `i_rst_n`=0 in LO → all outputs 0 immediately. After release and enable, the period is `RST_RATIO`.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: divided clock plus rise strobe, ratio changes only at period boundaries.
// Latency: start on the edge that samples i_clk_en; a new ratio takes effect at the next rising boundary (IDLE: next edge).
// Backpressure: none; a second ratio load before apply overwrites the shadow; stop waits for the end of the low phase.
//
// Ports:
//   i_ref_clk    reference clock, all flops on its rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clk_en     run request
//   i_div_ratio  new ratio N, captured when i_ratio_vld=1
//   i_ratio_vld  one-cycle load strobe
//   o_ratio_ack  one-cycle pulse when the pending ratio becomes active
//   o_busy       a loaded ratio is pending
//   o_div_clk    divided clock
//   o_rise_pls   high for the ref cycle in which o_div_clk rises
//
// Optional build macro: CLKDIV_BYPASS_EN -- when idle and enabled with an
// active ratio of 0 or 1, o_div_clk passes i_ref_clk straight through.

module clk_div_prog #(
   parameter int RATIO_W   = 8,
   parameter int RST_RATIO = 2
) (
   input  logic               i_ref_clk,
   input  logic               i_rst_n,
   input  logic               i_clk_en,
   input  logic [RATIO_W-1:0] i_div_ratio,
   input  logic               i_ratio_vld,
   output logic               o_ratio_ack,
   output logic               o_busy,
   output logic               o_div_clk,
   output logic               o_rise_pls
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HI   = 2'd1;
   localparam logic [1:0] ST_LO   = 2'd2;

   localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);
   localparam logic [RATIO_W-1:0] RATIO_TWO = RATIO_W'(2);
   localparam logic [RATIO_W-1:0] RATIO_RST = RATIO_W'(RST_RATIO);

   logic [1:0]         state_q, state_d;
   logic [RATIO_W-1:0] cnt_q, cnt_d;
   logic [RATIO_W-1:0] ratio_q, ratio_d;
   logic [RATIO_W-1:0] shadow_q;
   logic               pend_q;
   logic               div_q, div_d;
   logic               rise_q, rise_d;
   logic               ack_q;
   logic               apply;

   logic [RATIO_W-1:0] hi_len;
   logic [RATIO_W-1:0] lo_len;
   logic [RATIO_W-1:0] eff_ratio;
   logic               hi_last;
   logic               lo_last;

   // High phase is ceil(N/2), low phase floor(N/2): odd ratios get the
   // extra cycle on the high side.
   assign hi_len    = ratio_q - (ratio_q >> 1);
   assign lo_len    = ratio_q >> 1;
   assign hi_last   = (cnt_q == (hi_len - RATIO_ONE));
   assign lo_last   = (cnt_q == (lo_len - RATIO_ONE));
   // Ratio that will be active after any apply happening on this edge.
   assign eff_ratio = pend_q ? shadow_q : ratio_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      rise_d  = 1'b0;
      apply   = 1'b0;
      ratio_d = ratio_q;
      case (state_q)
         ST_IDLE: begin
            div_d = 1'b0;
            apply = pend_q;
            if (i_clk_en && (eff_ratio >= RATIO_TWO)) begin
               state_d = ST_HI;
               div_d   = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_HI: begin
            if (hi_last) begin
               state_d = ST_LO;
               div_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + RATIO_ONE;
            end
         end
         ST_LO: begin
            if (lo_last) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               // Only a continuing run is a boundary; a stop leaves any
               // pending ratio for the IDLE apply on the next edge.
               if (i_clk_en) begin
                  apply = pend_q;
                  if (eff_ratio >= RATIO_TWO) begin
                     state_d = ST_HI;
                     div_d   = 1'b1;
                     rise_d  = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + RATIO_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
      if (apply) begin
         ratio_d = shadow_q;
      end
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ratio_q  <= RATIO_RST;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         div_q    <= 1'b0;
         rise_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         div_q   <= div_d;
         rise_q  <= rise_d;
         ack_q   <= apply;
         if (i_ratio_vld) begin
            shadow_q <= i_div_ratio;
         end
         // A load on the apply edge itself re-arms pending for the next boundary.
         pend_q <= i_ratio_vld | (pend_q & ~apply);
      end
   end

   assign o_ratio_ack = ack_q;
   assign o_busy      = pend_q;
   assign o_rise_pls  = rise_q;

`ifdef CLKDIV_BYPASS_EN
   assign o_div_clk = ((state_q == ST_IDLE) && i_clk_en && (ratio_q < RATIO_TWO)) ?
                      i_ref_clk : div_q;
`else
   assign o_div_clk = div_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

   logic       i_ref_clk;
   logic       i_rst_n;
   logic       i_clk_en;
   logic [7:0] i_div_ratio;
   logic       i_ratio_vld;
   logic       o_ratio_ack;
   logic       o_busy;
   logic       o_div_clk;
   logic       o_rise_pls;

   int n_chk;
   int n_fail;

   typedef struct {
      logic       en;
      logic       vld;
      logic [7:0] ratio;
      logic       div;
      logic       rise;
      logic       ack;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   clk_div_prog #(.RATIO_W(8), .RST_RATIO(2)) dut (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_clk_en    (i_clk_en),
      .i_div_ratio (i_div_ratio),
      .i_ratio_vld (i_ratio_vld),
      .o_ratio_ack (o_ratio_ack),
      .o_busy      (o_busy),
      .o_div_clk   (o_div_clk),
      .o_rise_pls  (o_rise_pls)
   );

   initial i_ref_clk = 1'b0;
   always #5 i_ref_clk = ~i_ref_clk;

   function automatic vec_t mk(input logic en, input logic vld, input logic [7:0] r,
                               input logic d, input logic rs, input logic a, input logic b);
      vec_t v;
      v.en = en; v.vld = vld; v.ratio = r;
      v.div = d; v.rise = rs; v.ack = a; v.busy = b;
      return v;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic d, input logic rs, input logic a, input logic b);
      chk({tag, ".div"},  o_div_clk,   d);
      chk({tag, ".rise"}, o_rise_pls,  rs);
      chk({tag, ".ack"},  o_ratio_ack, a);
      chk({tag, ".busy"}, o_busy,      b);
   endtask

   // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic en, input logic vld, input logic [7:0] r);
      @(negedge i_ref_clk);
      i_clk_en    = en;
      i_ratio_vld = vld;
      i_div_ratio = r;
      @(posedge i_ref_clk);
      #1;
   endtask

   task automatic wait_ack(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b1, 1'b0, 8'd0);
         if (o_ratio_ack === 1'b1) seen = 1'b1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: ack not seen within 20 cycles, got 0 expected 1", tag);
      end
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      i_rst_n     = 1'b0;
      i_clk_en    = 1'b0;
      i_ratio_vld = 1'b0;
      i_div_ratio = 8'd0;

      // Even ratio from reset default (N=2), then stop.
      for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0, 0, (i % 2 == 0), (i % 2 == 0), 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      // Odd ratio N=5 loaded in IDLE: ack one edge after the load, then 3 high / 2 low.
      tbl.push_back(mk(0, 1, 5, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
      // Switch to N=4 mid-HI; applies at the next rise.
      tbl.push_back(mk(1, 1, 4, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0));
      // Running N=4, load N=7 mid-HI: 2 high, 2 low, then 4 high / 3 low.
      tbl.push_back(mk(1, 1, 7, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));

      // Reset state.
      repeat (2) @(posedge i_ref_clk);
      #1;
      chk4("reset", 0, 0, 0, 0);
      @(negedge i_ref_clk);
      i_rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].vld, tbl[i].ratio);
         chk4($sformatf("vec%0d", i), tbl[i].div, tbl[i].rise, tbl[i].ack, tbl[i].busy);
      end

      // Graceful stop: N=6, drop enable one cycle into HI.
      step(1'b1, 1'b1, 8'd6);
      chk("stop.load_busy", o_busy, 1'b1);
      wait_ack("stop.ack");
      chk("stop.ack_rise", o_rise_pls, 1'b1);
      chk("stop.ack_div", o_div_clk, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 8'd0);
         chk($sformatf("stop%0d.div", i), o_div_clk, (i <= 2));
         chk($sformatf("stop%0d.rise", i), o_rise_pls, 1'b0);
      end

      // Ratio 1 with enable: no bypass in the default build, output stays low.
      step(1'b0, 1'b1, 8'd1);
      chk("n1.busy", o_busy, 1'b1);
      step(1'b0, 1'b0, 8'd0);
      chk("n1.ack", o_ratio_ack, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 8'd0);
         chk($sformatf("n1_%0d.div", i), o_div_clk, 1'b0);
         chk($sformatf("n1_%0d.rise", i), o_rise_pls, 1'b0);
         #3;
         chk($sformatf("n1_%0d.div_mid", i), o_div_clk, 1'b0);
      end
      // Load N=3 while enabled: divided operation starts with the ack.
      step(1'b1, 1'b1, 8'd3);
      chk4("n3.load", 0, 0, 0, 1);
      step(1'b1, 1'b0, 8'd0);
      chk4("n3.start", 1, 1, 1, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("n3.hi2", 1, 0, 0, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("n3.lo", 0, 0, 0, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("n3.rise2", 1, 1, 0, 0);

      // Async reset mid-run: N=9, reset in LO with a load pending.
      step(1'b1, 1'b1, 8'd9);
      wait_ack("rst.ack");
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 1'b0, 8'd0);
         chk($sformatf("n9_%0d.div", i), o_div_clk, (i <= 4));
      end
      step(1'b1, 1'b1, 8'd4);
      chk4("n9.lo_load", 0, 0, 0, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk4("rst.async", 0, 0, 0, 0);
      @(posedge i_ref_clk);
      #1;
      chk4("rst.held", 0, 0, 0, 0);
      @(negedge i_ref_clk);
      i_rst_n     = 1'b1;
      i_clk_en    = 1'b1;
      i_ratio_vld = 1'b0;
      @(posedge i_ref_clk);
      #1;
      chk4("post.rise1", 1, 1, 0, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("post.lo", 0, 0, 0, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("post.rise2", 1, 1, 0, 0);
      step(1'b1, 1'b0, 8'd0);
      chk4("post.lo2", 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
